// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Sequential restoring divider, one quotient bit per clock.
//            Handles divide-by-zero and (optionally) signed overflow as
//            two-cycle fast paths that bypass the iterative loop.
// Config   : SEQ_DIVIDER_SIGNED_EN - when defined, is_signed selects
//            two's-complement DIV/REM; otherwise all operands are unsigned.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] quo_work;   // dividend bits shift out, quotient bits shift in
  logic [DATA_WIDTH:0]   rem_work;   // partial remainder, one guard bit wide
  logic [DATA_WIDTH-1:0] div_work;   // magnitude of the divisor
  logic                  zero_flag;

  // Operand preparation (magnitudes and special-case detection)
  logic [DATA_WIDTH-1:0] abs_dividend;
  logic [DATA_WIDTH-1:0] abs_divisor;
  logic                  quo_sign;
  logic                  rem_sign;
  logic                  overflow;
  logic                  divisor_zero;

  // Final-correction results
  logic [DATA_WIDTH-1:0] fix_quo;
  logic [DATA_WIDTH-1:0] fix_rem;

  assign divisor_zero = (divisor == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic dividend_neg;
  logic divisor_neg;
  logic q_neg;
  logic r_neg;

  assign dividend_neg = is_signed & dividend[DATA_WIDTH-1];
  assign divisor_neg  = is_signed & divisor[DATA_WIDTH-1];
  assign abs_dividend = dividend_neg ? (~dividend + 1'b1) : dividend;
  assign abs_divisor  = divisor_neg  ? (~divisor  + 1'b1) : divisor;
  assign quo_sign     = dividend_neg ^ divisor_neg;
  assign rem_sign     = dividend_neg;
  // The only signed quotient that does not fit: MOST_NEG / -1
  assign overflow     = is_signed & (dividend == MOST_NEG) & (divisor == '1);
  assign fix_quo      = q_neg ? (~quo_work + 1'b1) : quo_work;
  assign fix_rem      = r_neg ? (~rem_work[DATA_WIDTH-1:0] + 1'b1) : rem_work[DATA_WIDTH-1:0];
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign abs_dividend     = dividend;
  assign abs_divisor      = divisor;
  assign quo_sign         = 1'b0;
  assign rem_sign         = 1'b0;
  assign overflow         = 1'b0;
  assign fix_quo          = quo_work;
  assign fix_rem          = rem_work[DATA_WIDTH-1:0];
`endif

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor
  logic [DATA_WIDTH+1:0] shifted;
  logic [DATA_WIDTH+1:0] diff;
  logic                  take;

  assign shifted = {rem_work, quo_work[DATA_WIDTH-1]};
  assign diff    = shifted - {2'b00, div_work};
  assign take    = ~diff[DATA_WIDTH+1];

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      quo_work    <= '0;
      rem_work    <= '0;
      div_work    <= '0;
      zero_flag   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            count <= '0;
            if (divisor_zero) begin
              // Architectural divide-by-zero result; no sign correction
              quo_work  <= '1;
              rem_work  <= {1'b0, dividend};
              zero_flag <= 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
              q_neg     <= 1'b0;
              r_neg     <= 1'b0;
`endif
              state     <= FIX;
            end else if (overflow) begin
              quo_work  <= dividend;
              rem_work  <= '0;
              zero_flag <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
              q_neg     <= 1'b0;
              r_neg     <= 1'b0;
`endif
              state     <= FIX;
            end else begin
              quo_work  <= abs_dividend;
              rem_work  <= '0;
              div_work  <= abs_divisor;
              zero_flag <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
              q_neg     <= quo_sign;
              r_neg     <= rem_sign;
`endif
              state     <= RUN;
            end
          end
        end

        RUN: begin
          rem_work <= take ? diff[DATA_WIDTH:0] : shifted[DATA_WIDTH:0];
          quo_work <= {quo_work[DATA_WIDTH-2:0], take};
          if (count == LAST_STEP) begin
            count <= '0;
            state <= FIX;
          end else begin
            count <= count + 1'b1;
          end
        end

        FIX: begin
          quotient    <= fix_quo;
          remainder   <= fix_rem;
          div_by_zero <= zero_flag;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef SEQ_DIVIDER_SIGNED_EN
  // Sign outputs of operand preparation are constant zero in the unsigned build
  logic unused_signs;
  assign unused_signs = quo_sign | rem_sign;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider
// Purpose  : Directed self-checking bench for seq_divider (DATA_WIDTH = 32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_cmp;
  int n_bad;

  seq_divider #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation and wait (bounded) for done. lat counts rising
  // edges from the accepting edge (lat = 1) to the edge after which done is seen.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                       output int lat, output bit busy_ok);
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    is_signed = sg;
    start     = 1'b1;
    @(posedge clk);
    lat     = 1;
    busy_ok = 1'b1;
    #1;
    start = 1'b0;
    if (!busy) busy_ok = 1'b0;
    forever begin
      @(posedge clk);
      lat++;
      #1;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      if (lat >= 200) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({busy, done, div_by_zero} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b expected 000", {busy, done, div_by_zero}); end
    n_cmp++; if (quotient !== 32'h0) begin n_bad++; $display("FAIL reset_quotient: got %h expected 0", quotient); end
    n_cmp++; if (remainder !== 32'h0) begin n_bad++; $display("FAIL reset_remainder: got %h expected 0", remainder); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_div_zero();
    int lat; bit bok;
    do_op(32'd5, 32'd0, 1'b0, lat, bok);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL dz_latency: got %0d expected 2", lat); end
    n_cmp++; if (quotient !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dz_quotient: got %h expected ffffffff", quotient); end
    n_cmp++; if (remainder !== 32'd5) begin n_bad++; $display("FAIL dz_remainder: got %h expected 5", remainder); end
    n_cmp++; if (div_by_zero !== 1'b1) begin n_bad++; $display("FAIL dz_flag: got %b expected 1", div_by_zero); end
    // Results and flag must hold after the done pulse
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({done, div_by_zero, quotient, remainder} !== {1'b0, 1'b1, 32'hFFFF_FFFF, 32'd5}) begin
      n_bad++; $display("FAIL dz_hold: got done=%b dz=%b q=%h r=%h expected 0 1 ffffffff 5", done, div_by_zero, quotient, remainder);
    end
  endtask

  task automatic test_unsigned();
    int lat; bit bok;
    do_op(32'd100, 32'd7, 1'b0, lat, bok);
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL u_latency: got %0d expected 34", lat); end
    n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL u_busy: got busy_ok=%b expected 1", bok); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL u_busy_done: got %b expected 0", busy); end
    n_cmp++; if (quotient !== 32'd14) begin n_bad++; $display("FAIL u_quotient: got %0d expected 14", quotient); end
    n_cmp++; if (remainder !== 32'd2) begin n_bad++; $display("FAIL u_remainder: got %0d expected 2", remainder); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL u_dz_clear: got %b expected 0", div_by_zero); end
    @(posedge clk);
    #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL u_done_pulse: got %b expected 0", done); end
    // Unsigned interpretation of a negative-looking dividend (both builds)
    do_op(32'hFFFF_FFF9, 32'd2, 1'b0, lat, bok);
    n_cmp++; if ({quotient, remainder} !== {32'h7FFF_FFFC, 32'd1}) begin
      n_bad++; $display("FAIL u_big: got q=%h r=%h expected 7ffffffc 00000001", quotient, remainder);
    end
  endtask

  task automatic test_signed();
    int lat; bit bok;
    logic [31:0] eq1, er1, eq2, er2;
`ifdef SEQ_DIVIDER_SIGNED_EN
    eq1 = 32'hFFFF_FFFD; er1 = 32'hFFFF_FFFF;
    eq2 = 32'hFFFF_FFF2; er2 = 32'hFFFF_FFFE;
`else
    eq1 = 32'h7FFF_FFFC; er1 = 32'h0000_0001;
    eq2 = 32'h2492_4916; er2 = 32'h0000_0002;
`endif
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, lat, bok);
    n_cmp++; if ({quotient, remainder} !== {eq1, er1}) begin
      n_bad++; $display("FAIL s_m7_div_2: got q=%h r=%h expected %h %h", quotient, remainder, eq1, er1);
    end
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL s_latency: got %0d expected 34", lat); end
    do_op(32'hFFFF_FF9C, 32'd7, 1'b1, lat, bok);
    n_cmp++; if ({quotient, remainder} !== {eq2, er2}) begin
      n_bad++; $display("FAIL s_m100_div_7: got q=%h r=%h expected %h %h", quotient, remainder, eq2, er2);
    end
  endtask

  task automatic test_overflow();
    int lat; bit bok;
    logic [31:0] eq, er;
    int elat;
`ifdef SEQ_DIVIDER_SIGNED_EN
    eq = 32'h8000_0000; er = 32'h0; elat = 2;
`else
    eq = 32'h0; er = 32'h8000_0000; elat = 34;
`endif
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, bok);
    n_cmp++; if (lat !== elat) begin n_bad++; $display("FAIL ovf_latency: got %0d expected %0d", lat, elat); end
    n_cmp++; if ({quotient, remainder, div_by_zero} !== {eq, er, 1'b0}) begin
      n_bad++; $display("FAIL ovf_result: got q=%h r=%h dz=%b expected %h %h 0", quotient, remainder, div_by_zero, eq, er);
    end
  endtask

  task automatic test_ignore_start();
    int lat, ndone, first_lat;
    logic [31:0] q, r;
    ndone = 0; first_lat = 0; q = '0; r = '0;
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 10) begin
        start = 1'b1; dividend = 32'd9; divisor = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        if (first_lat == 0) first_lat = lat;
        q = quotient; r = remainder;
      end
    end
    n_cmp++; if (ndone !== 1) begin n_bad++; $display("FAIL ign_done_count: got %0d expected 1", ndone); end
    n_cmp++; if (first_lat !== 34) begin n_bad++; $display("FAIL ign_latency: got %0d expected 34", first_lat); end
    n_cmp++; if ({q, r} !== {32'd14, 32'd2}) begin n_bad++; $display("FAIL ign_result: got q=%0d r=%0d expected 14 2", q, r); end
  endtask

  task automatic test_back_to_back();
    int lat; bit bok;
    do_op(32'd100, 32'd7, 1'b0, lat, bok);
    // do_op returns in the done cycle, so this start lands on that cycle
    do_op(32'd77, 32'd8, 1'b0, lat, bok);
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL b2b_latency: got %0d expected 34", lat); end
    n_cmp++; if ({quotient, remainder} !== {32'd9, 32'd5}) begin n_bad++; $display("FAIL b2b_result: got q=%0d r=%0d expected 9 5", quotient, remainder); end
  endtask

  task automatic test_reset_abort();
    int lat, done_seen; bit bok;
    done_seen = 0;
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    start = 1'b0;
    while (lat < 15) begin
      @(posedge clk);
      lat++;
      #1;
    end
    reset = 1'b1;
    #1;
    n_cmp++; if ({busy, done, div_by_zero, quotient, remainder} !== 67'h0) begin
      n_bad++; $display("FAIL abort_outputs: got busy=%b done=%b dz=%b q=%h r=%h expected all 0", busy, done, div_by_zero, quotient, remainder);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    n_cmp++; if (done_seen !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d activity cycles expected 0", done_seen); end
    do_op(32'd50, 32'd5, 1'b0, lat, bok);
    n_cmp++; if ({quotient, remainder} !== {32'd10, 32'd0}) begin n_bad++; $display("FAIL abort_next: got q=%0d r=%0d expected 10 0", quotient, remainder); end
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL abort_next_latency: got %0d expected 34", lat); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_div_zero();
    test_unsigned();
    test_signed();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request pulse, sampled only in IDLE.
REQ-005 SHALL have port is_signed  input  1  1 = two's-complement DIV/REM, 0 = DIVU/REMU.
REQ-006 SHALL have port dividend  input  DATA_WIDTH  numerator, sampled with start.
REQ-007 SHALL have port divisor  input  DATA_WIDTH  denominator, sampled with start.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port quotient  output  DATA_WIDTH  registered quotient.
REQ-011 SHALL have port remainder  output  DATA_WIDTH  registered remainder.
REQ-012 SHALL have port div_by_zero  output  1  registered flag, valid with done, held until next done.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> FIX -> IDLE; special cases IDLE -> FIX directly.
REQ-014 SHALL latch operands on edge E where state=IDLE and start=1; start while busy is ignored, no effect.
REQ-015 SHALL in signed mode latch absolute values of operands plus quotient sign (dividend_msb XOR divisor_msb) and remainder sign (dividend_msb).
REQ-016 SHALL in RUN perform one restoring shift-subtract step per cycle, DATA_WIDTH steps counted by an internal counter, working remainder DATA_WIDTH+1 bits wide.
REQ-017 SHALL in FIX negate quotient/remainder per latched signs, register outputs, assert done for exactly one cycle, return to IDLE.
REQ-018 SHALL give normal latency: done high in cycle after edge E+DATA_WIDTH+1 (34 cycles at width 32).
REQ-019 SHALL on divisor=0: quotient=all ones, remainder=dividend (unmodified), div_by_zero=1, done after edge E+1.
REQ-020 SHALL on signed overflow (dividend=most-negative, divisor=all ones): quotient=dividend, remainder=0, div_by_zero=0, done after edge E+1.
REQ-021 SHALL accept a new start in the same cycle done is high, since state is IDLE then.
REQ-022 SHALL hold quotient, remainder, div_by_zero stable between done pulses.
REQ-023 SHALL make quotient*divisor+remainder=dividend (mod 2^DATA_WIDTH) with |remainder|<|divisor|, remainder sign = dividend sign.

Reset
REQ-024 SHALL on reset force state IDLE, counter 0, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
REQ-025 SHALL on reset during RUN/FIX abort the operation with no done pulse; first start after release begins cleanly.

Configuration
REQ-026 SHALL honour macro SEQ_DIVIDER_SIGNED_EN: defined -> REQ-015, REQ-017 sign correction and REQ-020 implemented.
REQ-027 SHALL when SEQ_DIVIDER_SIGNED_EN is undefined ignore is_signed, treat all operands unsigned, omit sign logic and overflow path; port list unchanged.

Verification
REQ-028 SHALL cover unsigned 100/7 -> quotient=14, remainder=2, done 34 cycles after start, busy high throughout.
REQ-029 SHALL cover signed 0xFFFFFFF9/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; macro undefined -> quotient=0x7FFFFFFC, remainder=1.
REQ-030 SHALL cover 5/0 -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, done 2 cycles after start.
REQ-031 SHALL cover signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, done 2 cycles after start.
REQ-032 SHALL cover start with 9/3 pulsed at cycle 10 of a running 100/7 -> ignored, single done with 14/2; back-to-back start on done cycle accepted.
REQ-033 SHALL cover reset asserted at cycle 15 of a running operation -> no done, all outputs 0, next 50/5 gives quotient=10, remainder=0.
